dcache_miss_handler: RTL and testbench
======================================

DCACHE_MISS_HANDLER -- requirements
Module: dcache_miss_handler

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset: clk and rst.
REQ-002 SHALL take parameters (name, default, meaning): LINE_BITS, 1024, cache line width; WORD_BITS, 32, memory beat width; BEATS, LINE_BITS/WORD_BITS (32), beats per line.
REQ-003 SHALL have these ports (name, direction, width, meaning):
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- read_repair_request  in  1  controller read-miss repair request
- write_repair_request  in  1  controller write-miss repair request
- missed_addr  in  32  missed byte address
- waddr_valid  out  1  line write to controller valid
- waddr  out  32  line write address
- wdata  out  LINE_BITS  filled line
- wmask  out  LINE_BITS/8  byte mask
- repair_resolved  out  1  repair complete pulse
- mem_req_valid  out  1  memory line-read request
- mem_req_ready  in  1  memory accepts request
- mem_req_addr  out  32  line-aligned address
- mem_rsp_valid  in  1  beat valid
- mem_rsp_data  in  WORD_BITS  beat data

Function
REQ-004 SHALL implement FSM states IDLE, REQ, FILL, WRITE, RESOLVE, DRAIN.
REQ-005 IDLE: if either request is high, SHALL latch missed_addr and the request type (read wins if both are high), clear the beat counter, and go to REQ next cycle.
REQ-006 REQ: SHALL hold mem_req_valid=1 with mem_req_addr = latched address with bits [6:0] zeroed; on mem_req_valid && mem_req_ready SHALL go to FILL.
REQ-007 FILL: each cycle with mem_rsp_valid SHALL store mem_rsp_data into wdata bits [32k+31:32k] for beat counter k, then increment k; the beat at k=BEATS-1 SHALL move the FSM to WRITE. Cycles without mem_rsp_valid SHALL stall with no change.
REQ-008 mem_rsp_valid outside FILL SHALL be ignored.
REQ-009 WRITE: SHALL assert waddr_valid=1 for exactly one cycle, with waddr = latched missed_addr (unaligned) and wmask all ones. SHALL then go to RESOLVE.
REQ-010 RESOLVE: SHALL assert repair_resolved=1 for exactly one cycle with waddr_valid=0, then go to DRAIN.
REQ-011 DRAIN: SHALL stay while either request is high and return to IDLE on the first cycle both are low, so one request level never triggers two repairs.
REQ-012 Deassertion of a request, or a change to missed_addr, after the IDLE latch SHALL be ignored; the repair SHALL complete with the latched values.
REQ-013 Minimum latency SHALL be: request seen in IDLE at cycle 0, then waddr_valid at cycle 0 + 2 + BEATS (one-cycle REQ handshake, back-to-back beats), then repair_resolved one cycle later.
REQ-014 wdata, waddr and wmask SHALL hold their values after WRITE until the next fill begins.

Reset
REQ-015 On rst, the FSM SHALL enter IDLE and the beat counter and latches SHALL clear.
REQ-016 On rst, outputs SHALL reset to: mem_req_valid=0, waddr_valid=0, repair_resolved=0, waddr=0, wdata=0, wmask=0, mem_req_addr=0.
REQ-017 Reset mid-fill SHALL abandon the fill. Beats still in flight afterwards SHALL be dropped under REQ-008.

Structure
REQ-018 CORE_PKG SHALL hold DCACHE_LINE_BITS, DCACHE_WORD_BITS, DCACHE_BEATS, the line-offset width (7), and the FSM state enum type.
REQ-019 One sub-module, dcache_line_fill_buffer, SHALL hold beat-indexed line storage (write-enable, beat index, clear); the FSM SHALL stay in dcache_miss_handler.

Verification
REQ-020 Read miss: read_repair_request=1 with missed_addr=32'hAABB_CCDD, mem_req_ready=1, 32 back-to-back beats of 32'h0000_0000+k -> mem_req_addr=32'hAABB_CC80, waddr=32'hAABB_CCDD, wdata word k = k, wmask all ones; waddr_valid at cycle 34, repair_resolved at cycle 35, one pulse each.
REQ-021 Write miss: write_repair_request=1 with missed_addr=32'h0000_0001, mem_req_ready held low 3 cycles -> mem_req_valid held 4 cycles, mem_req_addr=32'h0000_0000, repair completes normally.
REQ-022 Both requests high with missed_addr=32'h1000_0040 -> exactly one repair, read type latched, request held through DRAIN, no second mem_req_valid until both requests are low.
REQ-023 Gapped beats (mem_rsp_valid toggling every cycle) -> line still correct, waddr_valid at cycle 2+2*32 or later, no beat lost or duplicated.
REQ-024 rst asserted after 10 beats, then stray beats -> all outputs 0 next cycle; a new request to 32'h2000_0000 then fills a full, fresh 32-beat line.
REQ-025 Request dropped during FILL -> repair still completes, waddr equals the originally latched address.

Source files
------------

// File: rtl/core_pkg.sv
// rtl/core_pkg.sv - shared line geometry and miss-handler state type
package core_pkg;

    localparam int DCACHE_LINE_BITS = 1024;
    localparam int DCACHE_WORD_BITS = 32;
    localparam int DCACHE_BEATS     = DCACHE_LINE_BITS / DCACHE_WORD_BITS;
    localparam int LINE_OFF_BITS    = 7;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_FILL,
        ST_WRITE,
        ST_RESOLVE,
        ST_DRAIN
    } dcache_state_e;

endpackage

// File: rtl/dcache_line_fill_buffer.sv
// rtl/dcache_line_fill_buffer.sv - beat-indexed cache line assembly register
module dcache_line_fill_buffer
    import core_pkg::*;
#(
    parameter int LINE_BITS = DCACHE_LINE_BITS,
    parameter int WORD_BITS = DCACHE_WORD_BITS,
    parameter int BEATS     = LINE_BITS / WORD_BITS,
    parameter int IDX_W     = $clog2(BEATS)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clr_i,
    input  logic                 we_i,
    input  logic [IDX_W-1:0]     beat_idx_i,
    input  logic [WORD_BITS-1:0] beat_data_i,
    output logic [LINE_BITS-1:0] line_o
);

    logic [LINE_BITS-1:0] line_q;

    always_ff @(posedge clk) begin
        if (rst || clr_i) begin
            line_q <= '0;
        end else if (we_i) begin
            line_q[beat_idx_i*WORD_BITS +: WORD_BITS] <= beat_data_i;
        end
    end

    assign line_o = line_q;

endmodule

// File: rtl/dcache_miss_handler.sv
// rtl/dcache_miss_handler.sv - fetches a missed line from memory and hands it back to the cache controller
module dcache_miss_handler
    import core_pkg::*;
#(
    parameter int LINE_BITS = DCACHE_LINE_BITS,
    parameter int WORD_BITS = DCACHE_WORD_BITS,
    parameter int BEATS     = LINE_BITS / WORD_BITS
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   read_repair_request,
    input  logic                   write_repair_request,
    input  logic [31:0]            missed_addr,
    output logic                   waddr_valid,
    output logic [31:0]            waddr,
    output logic [LINE_BITS-1:0]   wdata,
    output logic [LINE_BITS/8-1:0] wmask,
    output logic                   repair_resolved,
    output logic                   mem_req_valid,
    input  logic                   mem_req_ready,
    output logic [31:0]            mem_req_addr,
    input  logic                   mem_rsp_valid,
    input  logic [WORD_BITS-1:0]   mem_rsp_data
);

    localparam int IDX_W = $clog2(BEATS);

    dcache_state_e          state_q, state_d;
    logic [31:0]            addr_q, addr_d;
    logic [IDX_W-1:0]       beat_q, beat_d;
    logic [LINE_BITS/8-1:0] wmask_q, wmask_d;
    logic                   buf_clr, buf_we;
    logic                   any_req;

    assign any_req = read_repair_request | write_repair_request;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            beat_q  <= '0;
            wmask_q <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            beat_q  <= beat_d;
            wmask_q <= wmask_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        addr_d          = addr_q;
        beat_d          = beat_q;
        wmask_d         = wmask_q;
        buf_clr         = 1'b0;
        buf_we          = 1'b0;
        mem_req_valid   = 1'b0;
        waddr_valid     = 1'b0;
        repair_resolved = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                // Read/write type only matters to the controller; the fill is identical.
                if (any_req) begin
                    addr_d  = missed_addr;
                    beat_d  = '0;
                    wmask_d = '0;
                    buf_clr = 1'b1;
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                mem_req_valid = 1'b1;
                if (mem_req_ready) begin
                    state_d = ST_FILL;
                end
            end
            ST_FILL: begin
                if (mem_rsp_valid) begin
                    buf_we = 1'b1;
                    beat_d = beat_q + 1'b1;
                    if (beat_q == IDX_W'(BEATS - 1)) begin
                        // Mask goes high together with waddr_valid and then holds.
                        wmask_d = '1;
                        state_d = ST_WRITE;
                    end
                end
            end
            ST_WRITE: begin
                waddr_valid = 1'b1;
                state_d     = ST_RESOLVE;
            end
            ST_RESOLVE: begin
                repair_resolved = 1'b1;
                state_d         = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (!any_req) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    dcache_line_fill_buffer #(
        .LINE_BITS (LINE_BITS),
        .WORD_BITS (WORD_BITS),
        .BEATS     (BEATS),
        .IDX_W     (IDX_W)
    ) u_fill_buf (
        .clk         (clk),
        .rst         (rst),
        .clr_i       (buf_clr),
        .we_i        (buf_we),
        .beat_idx_i  (beat_q),
        .beat_data_i (mem_rsp_data),
        .line_o      (wdata)
    );

    assign mem_req_addr = {addr_q[31:LINE_OFF_BITS], {LINE_OFF_BITS{1'b0}}};
    assign waddr        = addr_q;
    assign wmask        = wmask_q;

endmodule

// File: tb/tb_dcache_miss_handler.sv
// tb/tb_dcache_miss_handler.sv - directed self-checking bench for dcache_miss_handler
module tb_dcache_miss_handler;

    localparam int LINE_BITS = 1024;
    localparam int WORD_BITS = 32;
    localparam int BEATS     = 32;

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   read_repair_request;
    logic                   write_repair_request;
    logic [31:0]            missed_addr;
    logic                   waddr_valid;
    logic [31:0]            waddr;
    logic [LINE_BITS-1:0]   wdata;
    logic [LINE_BITS/8-1:0] wmask;
    logic                   repair_resolved;
    logic                   mem_req_valid;
    logic                   mem_req_ready;
    logic [31:0]            mem_req_addr;
    logic                   mem_rsp_valid;
    logic [WORD_BITS-1:0]   mem_rsp_data;

    int tests_run    = 0;
    int tests_failed = 0;

    int                     wv_cyc, wv_cnt, rr_cyc, rr_cnt, mrv_cnt;
    logic [31:0]            wv_addr, rq_addr;
    logic [LINE_BITS/8-1:0] wv_mask;
    bit                     timeout;

    always #5 clk = ~clk;

    dcache_miss_handler #(
        .LINE_BITS (LINE_BITS),
        .WORD_BITS (WORD_BITS),
        .BEATS     (BEATS)
    ) dut (
        .clk                  (clk),
        .rst                  (rst),
        .read_repair_request  (read_repair_request),
        .write_repair_request (write_repair_request),
        .missed_addr          (missed_addr),
        .waddr_valid          (waddr_valid),
        .waddr                (waddr),
        .wdata                (wdata),
        .wmask                (wmask),
        .repair_resolved      (repair_resolved),
        .mem_req_valid        (mem_req_valid),
        .mem_req_ready        (mem_req_ready),
        .mem_req_addr         (mem_req_addr),
        .mem_rsp_valid        (mem_rsp_valid),
        .mem_rsp_data         (mem_rsp_data)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Memory/controller stimulus for one repair; cycle 0 is the cycle the request is first seen.
    task automatic run_repair(input int ready_delay, input bit gap, input int drop_at,
                              input int hold_after, input logic [31:0] base);
        int cyc      = 0;
        int sent     = 0;
        int rv_seen  = 0;
        int drop_cyc = -1;
        bit filling  = 1'b0;
        bit phase    = 1'b0;
        wv_cyc = -1; wv_cnt = 0; rr_cyc = -1; rr_cnt = 0; mrv_cnt = 0;
        wv_addr = '0; wv_mask = '0; rq_addr = '0; timeout = 1'b0;
        while (1) begin
            mem_req_ready = (rv_seen >= ready_delay);
            if (filling && sent < BEATS) begin
                mem_rsp_valid = gap ? phase : 1'b1;
                phase         = ~phase;
                mem_rsp_data  = base + sent;
            end else begin
                mem_rsp_valid = 1'b0;
            end
            if (cyc == 2) missed_addr = ~missed_addr;
            if (cyc == drop_at) begin
                read_repair_request  = 1'b0;
                write_repair_request = 1'b0;
            end
            if (rr_cnt > 0 && drop_cyc < 0 && cyc >= rr_cyc + hold_after) begin
                read_repair_request  = 1'b0;
                write_repair_request = 1'b0;
                drop_cyc             = cyc;
            end
            if (mem_req_valid) begin
                if (rv_seen == 0) rq_addr = mem_req_addr;
                rv_seen++;
                mrv_cnt++;
            end
            if (waddr_valid) begin
                if (wv_cnt == 0) begin
                    wv_cyc  = cyc;
                    wv_addr = waddr;
                    wv_mask = wmask;
                end
                wv_cnt++;
            end
            if (repair_resolved) begin
                if (rr_cnt == 0) rr_cyc = cyc;
                rr_cnt++;
            end
            if (mem_rsp_valid) sent++;
            if (mem_req_valid && mem_req_ready) filling = 1'b1;
            if (drop_cyc >= 0 && cyc >= drop_cyc + 3) break;
            if (cyc >= 400) begin
                timeout = 1'b1;
                break;
            end
            step();
            cyc++;
        end
        mem_rsp_valid = 1'b0;
        mem_req_ready = 1'b0;
        tests_run++;
        if (timeout !== 1'b0) begin
            tests_failed++;
            $display("FAIL repair_timeout: no completion within 400 cycles (resolved=%0d)", rr_cnt);
        end
    endtask

    task automatic check_line(input string name, input logic [31:0] base);
        int bad = 0;
        logic [LINE_BITS-1:0] line;
        line = wdata;
        for (int k = 0; k < BEATS; k++) begin
            if (line[k*WORD_BITS +: WORD_BITS] !== base + k) bad++;
        end
        tests_run++;
        if (bad !== 0) begin
            tests_failed++;
            $display("FAIL %s: %0d of %0d words wrong, word0=%h expected %h", name, bad, BEATS,
                     line[WORD_BITS-1:0], base);
        end
    endtask

    task automatic check32(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        read_repair_request = 1'b0; write_repair_request = 1'b0;
        missed_addr = 32'h0; mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_data = '0;
        step(); step();
        rst = 1'b0;
        tests_run++;
        if ({mem_req_valid, waddr_valid, repair_resolved} !== 3'b000) begin
            tests_failed++;
            $display("FAIL reset_strobes: got %b expected 000", {mem_req_valid, waddr_valid, repair_resolved});
        end
        check32("reset_waddr", waddr, 32'h0);
        check32("reset_mem_req_addr", mem_req_addr, 32'h0);
        tests_run++;
        if (wdata !== '0 || wmask !== '0) begin
            tests_failed++;
            $display("FAIL reset_line: wdata/wmask nonzero, wmask=%h expected 0", wmask);
        end
        step();
    endtask

    task automatic test_read_miss();
        missed_addr = 32'hAABB_CCDD; read_repair_request = 1'b1;
        run_repair(0, 1'b0, 1, 0, 32'h0000_0000);
        check32("read_mem_req_addr", rq_addr, 32'hAABB_CC80);
        check32("read_waddr", wv_addr, 32'hAABB_CCDD);
        check32("read_wv_cycle", wv_cyc, 34);
        check32("read_rr_cycle", rr_cyc, 35);
        check32("read_pulse_counts", {wv_cnt[15:0], rr_cnt[15:0]}, {16'd1, 16'd1});
        tests_run++;
        if (wv_mask !== {(LINE_BITS/8){1'b1}}) begin
            tests_failed++;
            $display("FAIL read_wmask: got %h expected all ones", wv_mask);
        end
        check_line("read_line", 32'h0000_0000);
        step(); step();
        check32("read_waddr_held", waddr, 32'hAABB_CCDD);
        check_line("read_line_held", 32'h0000_0000);
    endtask

    task automatic test_write_miss();
        missed_addr = 32'h0000_0001; write_repair_request = 1'b1;
        run_repair(3, 1'b0, -1, 0, 32'h1111_0000);
        check32("write_req_valid_cycles", mrv_cnt, 4);
        check32("write_mem_req_addr", rq_addr, 32'h0000_0000);
        check32("write_waddr", wv_addr, 32'h0000_0001);
        check32("write_wv_cycle", wv_cyc, 37);
        check32("write_rr_cycle", rr_cyc, 38);
        check_line("write_line", 32'h1111_0000);
    endtask

    task automatic test_both_requests();
        missed_addr = 32'h1000_0040; read_repair_request = 1'b1; write_repair_request = 1'b1;
        run_repair(0, 1'b0, -1, 5, 32'h2222_0000);
        check32("both_req_valid_cycles", mrv_cnt, 1);
        check32("both_mem_req_addr", rq_addr, 32'h1000_0000);
        check32("both_pulse_counts", {wv_cnt[15:0], rr_cnt[15:0]}, {16'd1, 16'd1});
        check32("both_wv_cycle", wv_cyc, 34);
        check_line("both_line", 32'h2222_0000);
    endtask

    task automatic test_gapped_beats();
        missed_addr = 32'h0000_4444; read_repair_request = 1'b1;
        run_repair(0, 1'b1, 1, 0, 32'hC0DE_0000);
        check32("gap_wv_cycle", wv_cyc, 66);
        check32("gap_rr_cycle", rr_cyc, 67);
        check_line("gap_line", 32'hC0DE_0000);
    endtask

    task automatic test_reset_mid_fill();
        missed_addr = 32'h3000_0100; read_repair_request = 1'b1; mem_req_ready = 1'b1;
        step();
        read_repair_request = 1'b0;
        step();
        mem_req_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            mem_rsp_valid = 1'b1; mem_rsp_data = 32'hDEAD_0000 + i;
            step();
        end
        rst = 1'b1; mem_rsp_data = 32'hDEAD_00AA;
        step();
        rst = 1'b0;
        tests_run++;
        if ({mem_req_valid, waddr_valid, repair_resolved} !== 3'b000 || wdata !== '0 || wmask !== '0) begin
            tests_failed++;
            $display("FAIL midfill_reset_outputs: strobes=%b wmask=%h expected all zero",
                     {mem_req_valid, waddr_valid, repair_resolved}, wmask);
        end
        check32("midfill_reset_addrs", waddr | mem_req_addr, 32'h0);
        step(); step();
        tests_run++;
        if (wdata !== '0 || mem_req_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL stray_beats: wdata word0=%h req_valid=%b expected 0/0", wdata[31:0], mem_req_valid);
        end
        mem_rsp_valid = 1'b0;
        missed_addr = 32'h2000_0000; read_repair_request = 1'b1;
        run_repair(0, 1'b0, 1, 0, 32'h9000_0000);
        check32("refill_waddr", wv_addr, 32'h2000_0000);
        check32("refill_wv_cycle", wv_cyc, 34);
        check_line("refill_line", 32'h9000_0000);
    endtask

    task automatic test_drop_during_fill();
        missed_addr = 32'h0000_1234; write_repair_request = 1'b1;
        run_repair(0, 1'b0, 10, 0, 32'h7000_0000);
        check32("drop_waddr", wv_addr, 32'h0000_1234);
        check32("drop_resolved_count", rr_cnt, 1);
        check_line("drop_line", 32'h7000_0000);
    endtask

    initial begin
        test_reset();
        test_read_miss();
        test_write_miss();
        test_both_requests();
        test_gapped_beats();
        test_reset_mid_fill();
        test_drop_during_fill();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
